// File: rtl/store_checker.sv
// Store-bus checker: compares memory-stage writes against an ordered table of
// expected stores and holds a sticky pass/fail verdict with a failure code.
module store_checker #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1000,
    parameter logic [ADDR_W-1:0] IGN_LO = ADDR_W'(96),
    parameter logic [ADDR_W-1:0] IGN_HI = ADDR_W'(96),
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [DATA_W-1:0] cfg_mask,
    input  logic [CNT_W-1:0]  num_exp,
    input  logic              start,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              armed,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        fail_code,
    output logic [CNT_W-1:0]  match_idx,
    output logic [15:0]       ign_cnt,
    output logic [31:0]       cycle_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PASS, S_FAIL} state_t;

    localparam bit          TO_EN   = (TIMEOUT != 0);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT) - 32'd1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DATA_W-1:0] mask_mem [DEPTH];

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  match_idx_q, match_idx_d;
    logic [15:0]       ign_cnt_q, ign_cnt_d;
    logic [31:0]       cycle_cnt_q, cycle_cnt_d;
    logic [1:0]        fail_code_q, fail_code_d;
    logic              armed_q, done_q, pass_q, fail_q;

    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    logic [DATA_W-1:0] e_mask;
    logic              addr_eq, data_ok, in_ign, is_last;
    logic [CNT_W-1:0]  num_clamped;

    // Table is not reset; entries survive reset and are rewritten only when idle.
    always_ff @(posedge clk) begin
        if (cfg_we && (state_q != S_ARMED) && (int'(cfg_idx) < DEPTH)) begin
            addr_mem[cfg_idx] <= cfg_addr;
            data_mem[cfg_idx] <= cfg_data;
            mask_mem[cfg_idx] <= cfg_mask;
        end
    end

    always_comb begin
        e_addr      = addr_mem[match_idx_q[IDX_W-1:0]];
        e_data      = data_mem[match_idx_q[IDX_W-1:0]];
        e_mask      = mask_mem[match_idx_q[IDX_W-1:0]];
        addr_eq     = (mem_addr == e_addr);
        data_ok     = (((mem_wdata ^ e_data) & e_mask) == '0);
        in_ign      = (mem_addr >= IGN_LO) && (mem_addr <= IGN_HI);
        is_last     = (match_idx_q == (num_q - CNT_W'(1)));
        num_clamped = (int'(num_exp) > DEPTH) ? CNT_W'(DEPTH) : num_exp;
    end

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        match_idx_d = match_idx_q;
        ign_cnt_d   = ign_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        fail_code_d = fail_code_q;
        case (state_q)
            S_ARMED: begin
                if (mem_write && addr_eq && data_ok) begin
                    match_idx_d = match_idx_q + CNT_W'(1);
                    if (is_last) state_d = S_PASS;
                end else if (mem_write && in_ign) begin
                    if (ign_cnt_q != 16'hFFFF) ign_cnt_d = ign_cnt_q + 16'd1;
                end else if (mem_write && addr_eq) begin
                    state_d     = S_FAIL;
                    fail_code_d = 2'd1;
                end else if (mem_write) begin
                    state_d     = S_FAIL;
                    fail_code_d = 2'd2;
                end
                // A completing match or a failing store takes precedence over the watchdog.
                if (TO_EN && (state_d == S_ARMED) && (cycle_cnt_q == TO_LAST)) begin
                    state_d     = S_FAIL;
                    fail_code_d = 2'd3;
                end
                if ((state_d == S_ARMED) && (cycle_cnt_q != 32'hFFFF_FFFF))
                    cycle_cnt_d = cycle_cnt_q + 32'd1;
            end
            default: begin
                if (start) begin
                    num_d       = num_clamped;
                    match_idx_d = '0;
                    ign_cnt_d   = '0;
                    cycle_cnt_d = '0;
                    fail_code_d = 2'd0;
                    state_d     = (num_clamped == '0) ? S_PASS : S_ARMED;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            num_q       <= '0;
            match_idx_q <= '0;
            ign_cnt_q   <= '0;
            cycle_cnt_q <= '0;
            fail_code_q <= 2'd0;
            armed_q     <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            match_idx_q <= match_idx_d;
            ign_cnt_q   <= ign_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            fail_code_q <= fail_code_d;
            armed_q     <= (state_d == S_ARMED);
            done_q      <= (state_d == S_PASS) || (state_d == S_FAIL);
            pass_q      <= (state_d == S_PASS);
            fail_q      <= (state_d == S_FAIL);
        end
    end

    assign armed     = armed_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign fail_code = fail_code_q;
    assign match_idx = match_idx_q;
    assign ign_cnt   = ign_cnt_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: doc/store_checker.md
# store_checker

Parametrised store-bus checker for the pipelined RISC-V SoC: it watches the memory-stage write port (write enable, address, write data) and decides pass/fail against a programmable, ordered list of expected stores. It ignores stores that fall in a scratch address window and runs a cycle watchdog. It reports a sticky verdict with a failure code. It can sit in a simulation top beside `RSICV_Top` or be synthesised into an FPGA build as a self-check block.

## Interface
Parameters:
- ADDR_W, 32, store address width
- DATA_W, 32, store data width
- DEPTH, 4, maximum number of expected stores (≥1)
- TIMEOUT, 1000, watchdog limit in cycles while armed; 0 disables the watchdog
- IGN_LO, 96, lowest address of the ignore window (inclusive)
- IGN_HI, 96, highest address of the ignore window (inclusive); the window is empty if IGN_LO > IGN_HI

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- cfg_we  in  1  write one expected-store entry
- cfg_idx  in  clog2(DEPTH)  entry index
- cfg_addr  in  ADDR_W  expected address
- cfg_data  in  DATA_W  expected data
- cfg_mask  in  DATA_W  data compare mask (1 = bit compared)
- num_exp  in  clog2(DEPTH+1)  number of entries to check; sampled on start
- start  in  1  one-cycle pulse that arms the checker
- mem_write  in  1  store strobe (MemWriteM)
- mem_addr  in  ADDR_W  store address (DataAdrM)
- mem_wdata  in  DATA_W  store data (WriteDataM)
- armed  out  1  checker in ARMED
- done  out  1  verdict reached (sticky)
- pass  out  1  all expected stores seen in order
- fail  out  1  check failed
- fail_code  out  2  0 none, 1 data mismatch, 2 unexpected address, 3 timeout
- match_idx  out  clog2(DEPTH+1)  number of expected stores matched so far
- ign_cnt  out  16  ignored stores, saturating at 0xFFFF
- cycle_cnt  out  32  cycles spent armed, saturating

## Operation
- The FSM has four states: IDLE, ARMED, PASS, FAIL. Reset forces IDLE.
- cfg_we is accepted in IDLE, PASS and FAIL; it is ignored in ARMED. Table entries are not reset; software must write every used entry before start.
- start in IDLE/PASS/FAIL:
  - latches num_exp, clears match_idx, ign_cnt, cycle_cnt and fail_code;
  - goes to ARMED, or to PASS directly if num_exp == 0;
  - a num_exp above DEPTH is clamped to DEPTH.
- start in ARMED is ignored.
- ARMED, per cycle with mem_write = 1, with e = entry[match_idx], evaluated in priority order:
  1. mem_addr == e.addr and ((mem_wdata ^ e.data) & e.mask) == 0 → match; match_idx++. If this was the last entry (match_idx == num_exp−1) → PASS.
  2. mem_addr within [IGN_LO, IGN_HI] → ignored; ign_cnt++.
  3. mem_addr == e.addr with a data miscompare → FAIL, code 1.
  4. Any other address → FAIL, code 2.
- ARMED, every cycle: cycle_cnt++. If TIMEOUT ≠ 0 and cycle_cnt == TIMEOUT−1 with no completing match in that cycle → FAIL, code 3.
- Simultaneous events: a store that completes the list in the timeout cycle wins (PASS). A failing store in the timeout cycle reports its own code (1 or 2), not 3.
- mem_write is ignored outside ARMED.
- PASS and FAIL hold until start or reset. Counters and fail_code freeze there.
- Comparisons use full ADDR_W/DATA_W width; there is no alignment or byte-lane logic.

## Timing
- All outputs are registered. The verdict (done, pass/fail, fail_code) is visible the cycle after the deciding store edge.
- armed rises the cycle after start.
- Reset values: armed = done = pass = fail = 0, fail_code = 0, match_idx = 0, ign_cnt = 0, cycle_cnt = 0.
- Reset asserted mid-check immediately returns the block to IDLE with the values above. Table contents are retained.
- A cfg_we in the same cycle as start: the entry is written and start still arms. The written entry is usable from the next cycle.
- At most one store is evaluated per cycle. Back-to-back stores on consecutive cycles are all evaluated.

## Test plan
- entry0 = (100, 25, mask 0xFFFFFFFF), num_exp = 1, start; store (96, 7), then (100, 25) → ign_cnt = 1, pass = 1, done = 1 one cycle later, fail_code = 0.
- Same setup; store (100, 24) → fail = 1, fail_code = 1, match_idx = 0.
- Same setup; store (104, 25) → fail = 1, fail_code = 2.
- TIMEOUT = 20, no stores → fail = 1, fail_code = 3 exactly 20 cycles after armed rises, with cycle_cnt = 19. In a second run, store (100, 25) in that same cycle → pass = 1.
- num_exp = 3, entries (100, 1), (104, 2), (108, 0xAB with mask 0xFF); stores (100, 1), (104, 2), (108, 0x12AB) back-to-back → pass = 1, match_idx = 3. A second start with the order swapped → fail_code = 2 at the first store.
- Assert reset during ARMED after one match → all outputs 0 next cycle. Then start with no cfg writes → the previous table is still used and the run passes.
